hilo_div_sequencer: RTL
=======================

Name: hilo_div_sequencer

Overview:
- Multi-cycle HI/LO controller in the EX stage of the 5-stage pipeline.
- Accepts DIVU, MTHI, MTLO, MFHI and MFLO from EX and owns the architectural HI/LO registers.
- Sequences the shared iterative unsigned divider through its Signal encoding (DIVU = 6'b011011, PAUSE = 6'b000000) and stalls the pipeline until the quotient and remainder are captured.

Parameters:
DIV_LAT, 35, cycles from first DIVU-drive cycle through the divider's output-write cycle (RUN + DRAIN); must be >= 3
FN_MFHI, 6'b010000, funct code
FN_MTHI, 6'b010001, funct code
FN_MFLO, 6'b010010, funct code
FN_MTLO, 6'b010011, funct code
FN_DIVU, 6'b011011, funct code; also the value driven on div_signal

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high
ex_valid  in  1  EX holds a valid instruction
ex_funct  in  6  funct field of the EX instruction
ex_rs_val  in  32  rs operand (dividend / MT source)
ex_rt_val  in  32  rt operand (divisor)
flush  in  1  squash EX and any in-flight divide
div_signal  out  6  Signal to divider: DIVU or PAUSE
div_a  out  32  registered dividend to divider
div_b  out  32  registered divisor to divider
div_result  in  64  divider dataOut {remainder, quotient}
stall  out  1  freeze IF/ID/EX (combinational)
busy  out  1  state != IDLE
rd_data  out  32  HI or LO for MFHI/MFLO (combinational)
hi  out  32  HI register
lo  out  32  LO register
div_zero  out  1  only present with DIV_ZERO_EN

Behaviour:
- Reset values: state = IDLE; hi, lo, div_a, div_b = 0; div_signal = PAUSE; div_zero = 0; cnt = 0.
- States:
  - IDLE: no divide in flight.
  - RUN: div_signal = DIVU for DIV_LAT-1 cycles.
  - DRAIN: 1 cycle, div_signal = PAUSE; the divider writes dataOut.
  - CAPTURE: 1 cycle; div_result is valid.
- Cycle T, IDLE, ex_valid, funct = DIVU, no flush:
  - stall = 1.
  - At the edge: div_a <= ex_rs_val, div_b <= ex_rt_val, div_signal <= DIVU, cnt <= 0, state <= RUN, keep = 1.
- RUN: cnt increments each cycle. At cnt == DIV_LAT-2 the next state is DRAIN with div_signal <= PAUSE.
- DRAIN -> CAPTURE, unconditionally.
- CAPTURE:
  - If keep = 1: lo <= div_result[31:0], hi <= div_result[63:32].
  - Next state IDLE.
- Default timing: RUN T+1..T+34, DRAIN T+35, CAPTURE T+36.
  - Originating DIVU sees stall = 1 in T..T+35 and 0 in T+36.
  - New HI/LO are visible from T+37.
- While busy, any other ex_valid HI/LO op (MF*/MT*/DIVU) gets stall = 1 through CAPTURE. It proceeds in the following IDLE cycle.
- Non-HI/LO instructions never stall.
- MTHI/MTLO in IDLE with no stall: write hi/lo at the edge; no state change.
- MFHI/MFLO: rd_data = hi or lo, combinational, from current registers. In IDLE the value is final.
- rd_data = 0 for any other funct.
- flush:
  - In IDLE, it suppresses acceptance or an MT write that cycle.
  - In RUN/DRAIN, it clears keep. The sequence still runs to completion (the divider cannot be aborted), but CAPTURE discards the result, and the originating DIVU's stall deasserts from the next cycle.
  - flush and stall in the same cycle: flush wins, so stall = 0 for the squashed op.
- Simultaneous: CAPTURE with an MT op pending stays stalled, so there is no write conflict; the MT writes in the next IDLE.
- reset mid-operation returns to IDLE immediately. The divider shares the reset; no partial HI/LO update.
- All arithmetic is unsigned. Divisor 0 passes through the divider unchanged: it yields quotient 0xFFFFFFFF, remainder = dividend.

Optional Feature:
- Macro DIV_ZERO_EN.
- Defined:
  - A DIVU with ex_rt_val == 0 in IDLE bypasses the divider.
  - At the accepting edge: hi <= ex_rs_val, lo <= 32'hFFFFFFFF, div_zero <= 1 (one-cycle pulse).
  - Stall = 0; the state stays IDLE and div_signal stays PAUSE.
- Undefined: the div_zero port is absent and divisor 0 takes the full DIV_LAT+1 path with the same HI/LO values.

Test Plan:
- Reset, then DIVU rs=100 rt=7 at T -> stall high T..T+35, div_signal=DIVU T+1..T+34, PAUSE T+35; at T+37 lo=14, hi=2.
- DIVU 0xFFFFFFFF/0x10 followed by MFLO held in EX -> MFLO stalled through T+36; rd_data=0x0FFFFFFF, and hi=0xF.
- MTHI 0xDEADBEEF, then MTLO 0x12345678, then MFHI, then MFLO, with no divide -> no stall; rd_data 0xDEADBEEF then 0x12345678.
- DIVU 50/5 with flush at T+10 -> the sequence completes to IDLE at T+37, hi/lo keep their prior values (0/0 after reset), and stall=0 from T+11.
- reset asserted at T+20 during DIVU 9/3 -> next cycle busy=0, div_signal=PAUSE, hi=lo=0; a new DIVU 9/3 then gives lo=3, hi=0.
- DIVU 77/0 -> with DIV_ZERO_EN: hi=77, lo=0xFFFFFFFF at T+1, div_zero pulse, no stall. Without: same values at T+37.

Source files
------------

// File: rtl/hilo_div_sequencer.sv
// HI/LO register owner and iterative-divider sequencer for the EX stage.
// Optional macro DIV_ZERO_EN: divisor-zero DIVU bypasses the divider and pulses div_zero.
module hilo_div_sequencer #(
  parameter int          DIV_LAT = 35,
  parameter logic [5:0]  FN_MFHI = 6'b010000,
  parameter logic [5:0]  FN_MTHI = 6'b010001,
  parameter logic [5:0]  FN_MFLO = 6'b010010,
  parameter logic [5:0]  FN_MTLO = 6'b010011,
  parameter logic [5:0]  FN_DIVU = 6'b011011
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ex_valid,
  input  logic [5:0]  ex_funct,
  input  logic [31:0] ex_rs_val,
  input  logic [31:0] ex_rt_val,
  input  logic        flush,
  output logic [5:0]  div_signal,
  output logic [31:0] div_a,
  output logic [31:0] div_b,
  input  logic [63:0] div_result,
  output logic        stall,
  output logic        busy,
  output logic [31:0] rd_data,
  output logic [31:0] hi,
  output logic [31:0] lo
`ifdef DIV_ZERO_EN
  ,
  output logic        div_zero
`endif
);

  localparam logic [5:0] SIG_PAUSE = 6'b000000;
  localparam int         CNT_W     = $clog2(DIV_LAT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV_LAT - 2);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, CAPTURE} state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic             keep;

  logic is_div, is_mthi, is_mtlo, is_hilo, zero_byp, accept;

  assign is_div  = ex_valid && (ex_funct == FN_DIVU);
  assign is_mthi = ex_valid && (ex_funct == FN_MTHI);
  assign is_mtlo = ex_valid && (ex_funct == FN_MTLO);
  assign is_hilo = is_div || is_mthi || is_mtlo ||
                   (ex_valid && (ex_funct == FN_MFHI || ex_funct == FN_MFLO));

`ifdef DIV_ZERO_EN
  assign zero_byp = is_div && (ex_rt_val == 32'd0);
`else
  assign zero_byp = 1'b0;
`endif

  assign accept = (state == IDLE) && is_div && !flush && !zero_byp;
  assign busy   = (state != IDLE);

  always_comb begin
    rd_data = 32'd0;
    if (ex_funct == FN_MFHI)      rd_data = hi;
    else if (ex_funct == FN_MFLO) rd_data = lo;
  end

  // keep marks that EX still holds the originating DIVU; it is released in CAPTURE
  always_comb begin
    state_nxt = state;
    stall     = 1'b0;
    case (state)
      IDLE: begin
        stall = is_div && !zero_byp;
        if (accept) state_nxt = RUN;
      end
      RUN: begin
        stall = is_hilo;
        if (cnt == CNT_LAST) state_nxt = DRAIN;
      end
      DRAIN: begin
        stall     = is_hilo;
        state_nxt = CAPTURE;
      end
      CAPTURE: begin
        stall     = is_hilo && !(keep && is_div);
        state_nxt = IDLE;
      end
    endcase
    if (flush) stall = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= '0;
      keep       <= 1'b0;
      hi         <= 32'd0;
      lo         <= 32'd0;
      div_a      <= 32'd0;
      div_b      <= 32'd0;
      div_signal <= SIG_PAUSE;
`ifdef DIV_ZERO_EN
      div_zero   <= 1'b0;
`endif
    end else begin
      state <= state_nxt;
`ifdef DIV_ZERO_EN
      div_zero <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (accept) begin
            div_a      <= ex_rs_val;
            div_b      <= ex_rt_val;
            div_signal <= FN_DIVU;
            cnt        <= '0;
            keep       <= 1'b1;
          end
          if (!flush && is_mthi) hi <= ex_rs_val;
          if (!flush && is_mtlo) lo <= ex_rs_val;
`ifdef DIV_ZERO_EN
          if (!flush && zero_byp) begin
            hi       <= ex_rs_val;
            lo       <= 32'hFFFF_FFFF;
            div_zero <= 1'b1;
          end
`endif
        end
        RUN: begin
          cnt <= cnt + CNT_W'(1);
          if (cnt == CNT_LAST) div_signal <= SIG_PAUSE;
          if (flush) keep <= 1'b0;
        end
        DRAIN: begin
          if (flush) keep <= 1'b0;
        end
        CAPTURE: begin
          // divider output is {remainder, quotient}
          if (keep) begin
            lo <= div_result[31:0];
            hi <= div_result[63:32];
          end
          keep <= 1'b0;
        end
      endcase
    end
  end

endmodule
